// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_load_arbiter
// Purpose  : Round-robin arbiter that lets NREQ requesters load or clear
//            one shared register through active-low strobes.
// Revision : 1.0
// ============================================================================
module reg_load_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op_clr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic                  busy,
  output logic [WIDTH-1:0]      reg_data,
  output logic                  ld_bar,
  output logic                  clr_bar,
  output logic [7:0]            op_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Winner register doubles as the round-robin pointer; resetting it to the
  // last index makes requester 0 the first candidate after reset.
  localparam logic [IW-1:0] C_WIN_INIT = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_win;
  logic [NREQ-1:0]   r_gnt;
  logic              r_done;
  logic              r_busy;
  logic [WIDTH-1:0]  r_reg_data;
  logic              r_ld_bar;
  logic              r_clr_bar;
  logic [7:0]        r_op_count;

  logic [WIDTH-1:0]  w_data [NREQ];
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_pick;
  logic              w_any;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_data[g] = req_data[g*WIDTH +: WIDTH];
  end

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_win) + k) % NREQ);
      if (!w_any && req[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_win      <= C_WIN_INIT;
      r_gnt      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_reg_data <= '0;
      r_ld_bar   <= 1'b1;
      r_clr_bar  <= 1'b1;
      r_op_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_ISSUE;
            r_win      <= w_pick;
            r_gnt      <= NREQ'(1) << w_pick;
            r_busy     <= 1'b1;
            r_reg_data <= w_data[w_pick];
            if (op_clr[w_pick]) r_clr_bar <= 1'b0;
            else                r_ld_bar  <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_state    <= S_ACK;
          r_ld_bar   <= 1'b1;
          r_clr_bar  <= 1'b1;
          r_done     <= 1'b1;
          r_op_count <= r_op_count + 8'd1;
        end
        S_ACK: begin
          r_state <= S_RELEASE;
          r_done  <= 1'b0;
        end
        S_RELEASE: begin
          if (!req[r_win]) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign busy     = r_busy;
  assign reg_data = r_reg_data;
  assign ld_bar   = r_ld_bar;
  assign clr_bar  = r_clr_bar;
  assign op_count = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_load_arbiter
// Purpose  : Directed vector bench for reg_load_arbiter with a model of the
//            shared register it drives.
// Revision : 1.0
// ============================================================================
module tb_reg_load_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 8;
  localparam logic [23:0] DA = {8'h00, 8'hCC, 8'hAA};
  localparam logic [23:0] DR = {8'h0F, 8'h55, 8'hF0};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  op_clr;
  logic [23:0] req_data;
  logic [2:0]  gnt;
  logic        done;
  logic        busy;
  logic [7:0]  reg_data;
  logic        ld_bar;
  logic        clr_bar;
  logic [7:0]  op_count;
  logic [7:0]  ext_reg = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  opc;
    logic [23:0] d;
    logic [30:0] exp;
  } vec_t;
  vec_t vq[$];

  reg_load_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .op_clr(op_clr), .req_data(req_data),
    .gnt(gnt), .done(done), .busy(busy), .reg_data(reg_data),
    .ld_bar(ld_bar), .clr_bar(clr_bar), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared register fed by the strobes: synchronous clear wins over load.
  always @(posedge clk) begin
    if (!clr_bar)     ext_reg <= 8'h00;
    else if (!ld_bar) ext_reg <= reg_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] rq, input logic [2:0] oc,
                     input logic [23:0] d, input logic [2:0] g, input logic dn,
                     input logic b, input logic ld, input logic cl,
                     input logic [7:0] rd, input logic [7:0] c, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.req = rq; v.opc = oc; v.d = d;
    v.exp = {g, dn, b, ld, cl, rd, c, e};
    vq.push_back(v);
  endtask

  task automatic wait_sig(input bit want_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (want_done ? done : !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    bit all_ok;

    // rst, req, opc, data | gnt done busy ld clr reg_data op_count ext
    // Load 0xAA by requester 0
    add(0, 3'b001, 3'b000, DA, 3'b001, 0, 1, 0, 1, 8'hAA, 8'd0, 8'h00);
    add(0, 3'b001, 3'b000, DA, 3'b001, 1, 1, 1, 1, 8'hAA, 8'd1, 8'hAA);
    add(0, 3'b000, 3'b000, DA, 3'b001, 0, 1, 1, 1, 8'hAA, 8'd1, 8'hAA);
    add(0, 3'b000, 3'b000, DA, 3'b000, 0, 0, 1, 1, 8'hAA, 8'd1, 8'hAA);
    // Load 0xCC then clear, both by requester 1
    add(0, 3'b010, 3'b000, DA, 3'b010, 0, 1, 0, 1, 8'hCC, 8'd1, 8'hAA);
    add(0, 3'b010, 3'b000, DA, 3'b010, 1, 1, 1, 1, 8'hCC, 8'd2, 8'hCC);
    add(0, 3'b000, 3'b000, DA, 3'b010, 0, 1, 1, 1, 8'hCC, 8'd2, 8'hCC);
    add(0, 3'b000, 3'b000, DA, 3'b000, 0, 0, 1, 1, 8'hCC, 8'd2, 8'hCC);
    add(0, 3'b010, 3'b010, DA, 3'b010, 0, 1, 1, 0, 8'hCC, 8'd2, 8'hCC);
    add(0, 3'b010, 3'b010, DA, 3'b010, 1, 1, 1, 1, 8'hCC, 8'd3, 8'h00);
    add(0, 3'b000, 3'b000, DA, 3'b010, 0, 1, 1, 1, 8'hCC, 8'd3, 8'h00);
    add(0, 3'b000, 3'b000, DA, 3'b000, 0, 0, 1, 1, 8'hCC, 8'd3, 8'h00);
    // Reset, then three simultaneous loads in round-robin order
    add(1, 3'b000, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'h00, 8'd0, 8'h00);
    add(0, 3'b111, 3'b000, DR, 3'b001, 0, 1, 0, 1, 8'hF0, 8'd0, 8'h00);
    add(0, 3'b111, 3'b000, DR, 3'b001, 1, 1, 1, 1, 8'hF0, 8'd1, 8'hF0);
    add(0, 3'b110, 3'b000, DR, 3'b001, 0, 1, 1, 1, 8'hF0, 8'd1, 8'hF0);
    add(0, 3'b110, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'hF0, 8'd1, 8'hF0);
    add(0, 3'b110, 3'b000, DR, 3'b010, 0, 1, 0, 1, 8'h55, 8'd1, 8'hF0);
    add(0, 3'b110, 3'b000, DR, 3'b010, 1, 1, 1, 1, 8'h55, 8'd2, 8'h55);
    add(0, 3'b100, 3'b000, DR, 3'b010, 0, 1, 1, 1, 8'h55, 8'd2, 8'h55);
    add(0, 3'b100, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'h55, 8'd2, 8'h55);
    add(0, 3'b100, 3'b000, DR, 3'b100, 0, 1, 0, 1, 8'h0F, 8'd2, 8'h55);
    add(0, 3'b100, 3'b000, DR, 3'b100, 1, 1, 1, 1, 8'h0F, 8'd3, 8'h0F);
    add(0, 3'b000, 3'b000, DR, 3'b100, 0, 1, 1, 1, 8'h0F, 8'd3, 8'h0F);
    add(0, 3'b000, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'h0F, 8'd3, 8'h0F);
    // Fairness: requester 0 re-requests while 1 and 2 stay pending
    add(0, 3'b111, 3'b000, DR, 3'b001, 0, 1, 0, 1, 8'hF0, 8'd3, 8'h0F);
    add(0, 3'b111, 3'b000, DR, 3'b001, 1, 1, 1, 1, 8'hF0, 8'd4, 8'hF0);
    add(0, 3'b110, 3'b000, DR, 3'b001, 0, 1, 1, 1, 8'hF0, 8'd4, 8'hF0);
    add(0, 3'b110, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'hF0, 8'd4, 8'hF0);
    add(0, 3'b111, 3'b000, DR, 3'b010, 0, 1, 0, 1, 8'h55, 8'd4, 8'hF0);
    add(0, 3'b111, 3'b000, DR, 3'b010, 1, 1, 1, 1, 8'h55, 8'd5, 8'h55);
    add(0, 3'b101, 3'b000, DR, 3'b010, 0, 1, 1, 1, 8'h55, 8'd5, 8'h55);
    add(0, 3'b101, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'h55, 8'd5, 8'h55);
    add(0, 3'b101, 3'b000, DR, 3'b100, 0, 1, 0, 1, 8'h0F, 8'd5, 8'h55);
    add(0, 3'b101, 3'b000, DR, 3'b100, 1, 1, 1, 1, 8'h0F, 8'd6, 8'h0F);
    add(0, 3'b001, 3'b000, DR, 3'b100, 0, 1, 1, 1, 8'h0F, 8'd6, 8'h0F);
    add(0, 3'b001, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'h0F, 8'd6, 8'h0F);
    add(0, 3'b001, 3'b000, DR, 3'b001, 0, 1, 0, 1, 8'hF0, 8'd6, 8'h0F);
    add(0, 3'b001, 3'b000, DR, 3'b001, 1, 1, 1, 1, 8'hF0, 8'd7, 8'hF0);
    add(0, 3'b000, 3'b000, DR, 3'b001, 0, 1, 1, 1, 8'hF0, 8'd7, 8'hF0);
    add(0, 3'b000, 3'b000, DR, 3'b000, 0, 0, 1, 1, 8'hF0, 8'd7, 8'hF0);

    rst = 1'b1; req = '0; op_clr = '0; req_data = '0;
    #12;
    chk("reset_state", {16'h0, gnt, done, busy, ld_bar, clr_bar, reg_data},
        {16'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
    chk("reset_count", {24'h0, op_count}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; req = vq[i].req; op_clr = vq[i].opc; req_data = vq[i].d;
      tick();
      chk($sformatf("vec%0d", i),
          {1'b0, gnt, done, busy, ld_bar, clr_bar, reg_data, op_count, ext_reg},
          {1'b0, vq[i].exp});
    end

    // Reset asserted in the middle of an ISSUE cycle
    req_data = {8'h0F, 8'h33, 8'h77}; req = 3'b010; op_clr = 3'b000;
    tick();
    chk("rst_mid_pre", {28'h0, gnt, ld_bar}, {28'h0, 3'b010, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_async", {16'h0, gnt, done, busy, ld_bar, clr_bar, op_count},
        {16'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0});
    tick();
    chk("rst_mid_reg", {24'h0, ext_reg}, {24'h0, 8'hF0});
    rst = 1'b0; req = 3'b011;
    tick();
    chk("rst_first_gnt", {24'h0, gnt, ld_bar, reg_data[3:0]}, {24'h0, 3'b001, 1'b0, 4'h7});
    req = 3'b000;
    tick();
    chk("rst_after_ack", {16'h0, done, ext_reg, op_count[6:0]}, {16'h0, 1'b1, 8'h77, 7'd1});
    wait_sig(1'b0, ok);
    chk("rst_after_idle", {31'h0, ok}, 32'd1);

    // Winner drops req and changes its data/op during ISSUE
    req_data = {8'h5A, 8'h33, 8'h77}; req = 3'b100; op_clr = 3'b000;
    tick();
    chk("late_issue", {21'h0, gnt, ld_bar, clr_bar, reg_data}, {21'h0, 3'b100, 1'b0, 1'b1, 8'h5A});
    req_data = {8'hA5, 8'h33, 8'h77}; op_clr = 3'b100; req = 3'b000;
    tick();
    chk("late_ack", {20'h0, done, busy, clr_bar, ext_reg, reg_data[0]},
        {20'h0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0});
    tick();
    chk("late_release", {29'h0, gnt[2], done, busy}, {29'h0, 1'b1, 1'b0, 1'b1});
    tick();
    chk("late_idle", {28'h0, gnt, busy}, {28'h0, 3'b000, 1'b0});

    // Counter wrap after 256 completions
    rst = 1'b1; #2 rst = 1'b0;
    all_ok = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      req = 3'b001;
      wait_sig(1'b1, ok);
      all_ok &= ok;
      req = 3'b000;
      wait_sig(1'b0, ok);
      all_ok &= ok;
      if (n == 255) chk("cnt_255", {24'h0, op_count}, 32'd255);
    end
    chk("wrap_handshake", {31'h0, all_ok}, 32'd1);
    chk("cnt_wrap", {24'h0, op_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
